systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/npu_pkg.sv | 20 ++
 rtl/skew_line.sv | 28 ++
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_feeder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU constants: array operation encodings and feeder FSM states.
package npu_pkg;

   localparam int unsigned OP_WIDTH = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_NOP = 3'd0,
      OP_CLR = 3'd1,
      OP_MAC = 3'd2
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line for one array lane; dout is the last register of the chain.
module skew_line #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH*WIDTH-1:0] pipe_q;

   if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
         if (reset) pipe_q <= '0;
         else       pipe_q <= din;
      end
   end else begin : g_chain
      always_ff @(posedge clk) begin
         if (reset) pipe_q <= '0;
         else       pipe_q <= {pipe_q[(DEPTH-1)*WIDTH-1:0], din};
      end
   end

   assign dout = pipe_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/systolic_feeder.sv
// Streams k_len activation/weight vector pairs into a systolic array with per-lane skew.
// Optional macro FEEDER_STALL_CNT_EN enables the saturating stall_cycles counter.
module systolic_feeder
   import npu_pkg::*;
#(
   parameter int unsigned ARRAY_N   = 16,
   parameter int unsigned ARRAY_M   = 16,
   parameter int unsigned ACT_WIDTH = 8,
   parameter int unsigned WGT_WIDTH = 8,
   parameter int unsigned K_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [K_WIDTH-1:0]           k_len,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ARRAY_N*ACT_WIDTH-1:0] act_vec_in,
   input  logic [ARRAY_M*WGT_WIDTH-1:0] wgt_vec_in,
   output logic [ARRAY_N*ACT_WIDTH-1:0] act_data_set_out,
   output logic [ARRAY_M*WGT_WIDTH-1:0] wgt_data_set_out,
   output logic [2:0]                   operation_signal_out,
   output logic                         busy,
   output logic                         done,
   output logic [31:0]                  stall_cycles
);

   localparam int unsigned DRAIN_CYCLES = ARRAY_N + ARRAY_M - 1;
   localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

   state_e               state_q, state_d;
   logic [K_WIDTH-1:0]   k_len_q, k_len_d;
   logic [K_WIDTH-1:0]   acc_q, acc_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 in_ready_d, busy_d, done_d;
   logic [2:0]           op_d;
   logic                 xfer_c;
   logic [ARRAY_N*ACT_WIDTH-1:0] act_push_c;
   logic [ARRAY_M*WGT_WIDTH-1:0] wgt_push_c;

   assign xfer_c = in_valid & in_ready;

   // Non-transfer cycles push zero lanes so bubbles add nothing to the MAC.
   assign act_push_c = xfer_c ? act_vec_in : '0;
   assign wgt_push_c = xfer_c ? wgt_vec_in : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q              <= ST_IDLE;
         k_len_q              <= '0;
         acc_q                <= '0;
         drain_q              <= '0;
         in_ready             <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         operation_signal_out <= OP_NOP;
      end else begin
         state_q              <= state_d;
         k_len_q              <= k_len_d;
         acc_q                <= acc_d;
         drain_q              <= drain_d;
         in_ready             <= in_ready_d;
         busy                 <= busy_d;
         done                 <= done_d;
         operation_signal_out <= op_d;
      end
   end

   // Next state, plus registered outputs decoded from the next state.
   always_comb begin
      state_d    = state_q;
      k_len_d    = k_len_q;
      acc_d      = acc_q;
      drain_d    = drain_q;
      op_d       = OP_NOP;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      in_ready_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               k_len_d = k_len;
               acc_d   = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: state_d = (k_len_q == '0) ? ST_DONE : ST_STREAM;
         ST_STREAM: begin
            if (xfer_c) begin
               acc_d = acc_q + K_WIDTH'(1);
               if (acc_d == k_len_q) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q + DRAIN_W'(1);
            if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      in_ready_d = (state_d == ST_STREAM) && (acc_d < k_len_d);
      if (state_d == ST_CLEAR) op_d = OP_CLR;
      else if (state_d == ST_STREAM || state_d == ST_DRAIN) op_d = OP_MAC;
   end

   for (genvar n = 0; n < ARRAY_N; n++) begin : g_act
      skew_line #(.WIDTH(ACT_WIDTH), .DEPTH(n + 1)) u_skew (
         .clk  (clk),
         .reset(reset),
         .din  (act_push_c[n*ACT_WIDTH +: ACT_WIDTH]),
         .dout (act_data_set_out[n*ACT_WIDTH +: ACT_WIDTH])
      );
   end

   for (genvar m = 0; m < ARRAY_M; m++) begin : g_wgt
      skew_line #(.WIDTH(WGT_WIDTH), .DEPTH(m + 1)) u_skew (
         .clk  (clk),
         .reset(reset),
         .din  (wgt_push_c[m*WGT_WIDTH +: WGT_WIDTH]),
         .dout (wgt_data_set_out[m*WGT_WIDTH +: WGT_WIDTH])
      );
   end

`ifdef FEEDER_STALL_CNT_EN
   // Counts STREAM cycles where the feeder was ready but upstream had nothing.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (state_q == ST_IDLE && start) begin
         stall_cycles <= '0;
      end else if (state_q == ST_STREAM && in_ready && !in_valid && stall_cycles != '1) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-cycle control expectations plus a queue of pushed vectors.
module tb_systolic_feeder;
   import npu_pkg::*;

   localparam int N     = 16;
   localparam int M     = 16;
   localparam int AW    = 8;
   localparam int WW    = 8;
   localparam int KW    = 16;
   localparam int AV    = N * AW;
   localparam int WV    = M * WW;
   localparam int DRAIN = N + M - 1;
   localparam int HIST  = 16;
`ifdef FEEDER_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, in_valid;
   logic [KW-1:0] k_len;
   logic          in_ready, busy, done;
   logic [AV-1:0] act_vec_in, act_data_set_out;
   logic [WV-1:0] wgt_vec_in, wgt_data_set_out;
   logic [2:0]    operation_signal_out;
   logic [31:0]   stall_cycles;

   typedef struct packed {
      logic [AV-1:0] act;
      logic [WV-1:0] wgt;
   } pair_t;

   pair_t       hist[$];
   int          total = 0;
   int          bad   = 0;
   logic [2:0]  exp_op;
   logic        exp_busy, exp_done, exp_rdy;
   logic [31:0] exp_stall;

   always #5 clk = ~clk;

   systolic_feeder #(
      .ARRAY_N(N), .ARRAY_M(M), .ACT_WIDTH(AW), .WGT_WIDTH(WW), .K_WIDTH(KW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .k_len               (k_len),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .act_vec_in          (act_vec_in),
      .wgt_vec_in          (wgt_vec_in),
      .act_data_set_out    (act_data_set_out),
      .wgt_data_set_out    (wgt_data_set_out),
      .operation_signal_out(operation_signal_out),
      .busy                (busy),
      .done                (done),
      .stall_cycles        (stall_cycles)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_exp(input logic [2:0] op, input logic b, input logic d, input logic r);
      exp_op   = op;
      exp_busy = b;
      exp_done = d;
      exp_rdy  = r;
   endtask

   // Newest push at hist[0]; lane n shows what was pushed n+1 cycles ago.
   task automatic push_model(input logic xfer);
      pair_t p;
      p = '0;
      if (xfer) begin
         p.act = act_vec_in;
         p.wgt = wgt_vec_in;
      end
      hist.push_front(p);
      void'(hist.pop_back());
   endtask

   task automatic clear_model();
      hist.delete();
      for (int i = 0; i < HIST; i++) hist.push_back('0);
   endtask

   task automatic rand_data();
      act_vec_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      wgt_vec_in = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic sample();
      logic [AV-1:0] ea;
      logic [WV-1:0] ew;
      @(posedge clk);
      #1;
      for (int n = 0; n < N; n++) ea[n*AW +: AW] = hist[n].act[n*AW +: AW];
      for (int m = 0; m < M; m++) ew[m*WW +: WW] = hist[m].wgt[m*WW +: WW];
      chk("op",       256'(operation_signal_out), 256'(exp_op));
      chk("busy",     256'(busy),                 256'(exp_busy));
      chk("done",     256'(done),                 256'(exp_done));
      chk("in_ready", 256'(in_ready),             256'(exp_rdy));
      chk("act",      256'(act_data_set_out),     256'(ea));
      chk("wgt",      256'(wgt_data_set_out),     256'(ew));
      chk("stall",    256'(stall_cycles),         256'(exp_stall));
   endtask

   // gap bit i drops in_valid on STREAM cycle i; restart_at re-pulses start; rst_at resets in that DRAIN cycle.
   task automatic run_pass(input int k, input logic [31:0] gap, input bit special,
                           input int restart_at, input int rst_at);
      int xfers = 0;
      int scyc  = 0;
      int dcyc  = 0;
      int guard = 0;
      int phase;
      bit fin   = 1'b0;

      sample();
      start = 1'b1; k_len = KW'(k); in_valid = 1'b0; rand_data();
      push_model(1'b0);
      set_exp(OP_NOP, 1'b1, 1'b0, 1'b0);
      exp_op    = OP_CLR;
      exp_stall = '0;

      sample();
      start = 1'b0; in_valid = 1'b1; rand_data();
      push_model(1'b0);
      if (k == 0) begin
         set_exp(OP_NOP, 1'b1, 1'b1, 1'b0);
         phase = 2;
      end else begin
         set_exp(OP_MAC, 1'b1, 1'b0, 1'b1);
         phase = 0;
      end

      while (!fin && guard < 300) begin
         guard++;
         sample();
         start = 1'b0;
         case (phase)
            0: begin
               in_valid = (scyc < 32) ? !gap[scyc] : 1'b1;
               rand_data();
               if (special && in_valid && xfers == 0) begin
                  act_vec_in            = '0;
                  act_vec_in[7:0]       = 8'h11;
                  act_vec_in[AV-1 -: 8] = 8'hFF;
               end
               if (scyc == restart_at) begin
                  start = 1'b1;
                  k_len = KW'(9);
               end
               if (!in_valid && STALL_EN) exp_stall = exp_stall + 32'd1;
               push_model(in_valid);
               if (in_valid) xfers++;
               scyc++;
               if (xfers == k) begin
                  set_exp(OP_MAC, 1'b1, 1'b0, 1'b0);
                  phase = 1;
               end
            end
            1: begin
               dcyc++;
               in_valid = 1'($urandom_range(0, 1));
               rand_data();
               push_model(1'b0);
               if (dcyc == rst_at) begin
                  reset = 1'b1;
                  clear_model();
                  set_exp(OP_NOP, 1'b0, 1'b0, 1'b0);
                  exp_stall = '0;
                  fin = 1'b1;
               end else if (dcyc == DRAIN) begin
                  set_exp(OP_NOP, 1'b1, 1'b1, 1'b0);
                  phase = 2;
               end
            end
            default: begin
               in_valid = 1'b0;
               push_model(1'b0);
               set_exp(OP_NOP, 1'b0, 1'b0, 1'b0);
               fin = 1'b1;
            end
         endcase
      end
      chk("pass_end", 256'(fin), 256'(1));

      if (reset) begin
         sample();
         reset = 1'b0;
         push_model(1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0;
      act_vec_in = '0; wgt_vec_in = '0;
      clear_model();
      set_exp(OP_NOP, 1'b0, 1'b0, 1'b0);
      exp_stall = '0;

      sample();
      sample();
      reset = 1'b0;
      push_model(1'b0);

      run_pass(4, 32'h0,  1'b0, -1, -1);
      run_pass(1, 32'h0,  1'b1, -1, -1);
      run_pass(3, 32'h6,  1'b0, -1, -1);
      run_pass(0, 32'h0,  1'b0, -1, -1);
      run_pass(2, 32'h0,  1'b0,  0, -1);
      run_pass(5, 32'h5,  1'b0, -1,  5);
      run_pass(6, 32'h2A, 1'b0, -1, -1);
      sample();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
